instr_decode: RTL and testbench

Instruction register and field decoder sitting directly upstream of `controlPulses`. On request from the sequencer it fetches one 15-bit instruction word from memory, applies any pending INDEX modification, and holds the decoded `opcode`, `qc`, `extracode` and address fields stable for `controlPulses` until the next fetch. It also owns the EXTEND latch: `controlPulses` raises `ext_flag` when it executes EXTEND, and this block turns that into `extracode` for exactly the following instruction.

---
 rtl/agc_pkg.sv | 43 ++++
 rtl/instr_decode_index_mod.sv | 49 ++++
 rtl/instr_decode.sv | 132 +++++++++++++
 tb/tb_instr_decode.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// agc_pkg: shared constants and types for the instruction-path blocks
// (instr_decode, index_mod, controlPulses).
//   - WORD_W / ADDR_W : instruction word and address-field widths
//   - field positions : opcode, quarter-code and address bit ranges
//   - opcode constants: values controlPulses compares against
//   - ir_state_t      : instruction-register fetch FSM encoding
package agc_pkg;

    localparam int WORD_W  = 15;
    localparam int ADDR_W  = 12;

    localparam int OPC_HI  = 14;
    localparam int OPC_LO  = 12;
    localparam int QC_HI   = 11;
    localparam int QC_LO   = 10;
    localparam int ADDR_HI = 11;

    localparam logic [2:0] OPC_TC   = 3'd0;
    localparam logic [2:0] OPC_CCS  = 3'd1;
    localparam logic [2:0] OPC_DAS  = 3'd2;
    localparam logic [2:0] OPC_CA   = 3'd3;
    localparam logic [2:0] OPC_CS   = 3'd4;
    localparam logic [2:0] OPC_EXT  = 3'd5;
    localparam logic [2:0] OPC_TS   = 3'd6;
    localparam logic [2:0] OPC_MASK = 3'd7;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        WAIT_MEM = 2'd1,
        HOLD     = 2'd2
    } ir_state_t;

    // Opcode field of a full instruction word.
    function automatic logic [2:0] opc_of(input logic [WORD_W-1:0] word);
        opc_of = word[OPC_HI:OPC_LO];
    endfunction

    // Quarter-code field of a full instruction word.
    function automatic logic [1:0] qc_of(input logic [WORD_W-1:0] word);
        qc_of = word[QC_HI:QC_LO];
    endfunction

endpackage

// File: rtl/instr_decode_index_mod.sv
// index_mod: holds the pending INDEX value and adds it to the incoming
// instruction word.
//   clk, rst_n   : clock, async active-low reset
//   index_wr_i   : INDEX executed, load index_val_i
//   index_val_i  : value to add to the next captured word
//   capture_i    : the instruction register captures this edge
//   word_i       : raw word from memory
//   word_mod_o   : word_i + index_reg, modulo 2^WORD_W
module index_mod
    import agc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              index_wr_i,
    input  logic [WORD_W-1:0] index_val_i,
    input  logic              capture_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] word_mod_o
);

    logic [WORD_W-1:0] index_d;
    logic [WORD_W-1:0] index_q;

    // Next index value: a new write beats the clear-on-capture so that an
    // INDEX coinciding with a capture survives for the following word.
    always_comb begin
        index_d = index_q;
        if (index_wr_i) begin
            index_d = index_val_i;
        end else if (capture_i) begin
            index_d = {WORD_W{1'b0}};
        end else begin
            index_d = index_q;
        end
    end

    // Index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q <= {WORD_W{1'b0}};
        end else begin
            index_q <= index_d;
        end
    end

    // Same-width add: the carry out of the top bit is dropped.
    assign word_mod_o = word_i + index_q;

endmodule

// File: rtl/instr_decode.sv
// instr_decode: instruction register and field decoder feeding controlPulses.
// Fetches one word on ir_load, applies pending INDEX, holds decoded fields
// until the next fetch, and turns EXTEND into extracode for the next word.
//   clk, rst_n : clock, async active-low reset
//   ir_load    : fetch request from controlPulses (ignored while fetching)
//   mem_rdata  : instruction word from memory; mem_valid qualifies it
//   ext_flag   : EXTEND executed, marks the next fetched word as extracode
//   index_wr   : INDEX executed, index_val added to the next fetched word
//   fetch_req  : memory read request, high while a fetch is outstanding
//   ir         : held (modified) instruction word
//   opcode/qc/addr : fields of ir
//   extracode  : held instruction is an extracode
//   ir_valid   : a valid instruction is held
module instr_decode
    import agc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ir_load,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_valid,
    input  logic              ext_flag,
    input  logic              index_wr,
    input  logic [WORD_W-1:0] index_val,
    output logic              fetch_req,
    output logic [WORD_W-1:0] ir,
    output logic [2:0]        opcode,
    output logic [1:0]        qc,
    output logic [ADDR_W-1:0] addr,
    output logic              extracode,
    output logic              ir_valid
);

    ir_state_t         state_d,       state_q;
    logic [WORD_W-1:0] ir_d,          ir_q;
    logic              extracode_d,   extracode_q;
    logic              ext_pending_d, ext_pending_q;
    logic              fetch_req_d,   fetch_req_q;
    logic              ir_valid_d,    ir_valid_q;
    logic              capture_s;
    logic [WORD_W-1:0] word_mod_s;

    // INDEX storage and modular add.
    index_mod u_index_mod (
        .clk         (clk),
        .rst_n       (rst_n),
        .index_wr_i  (index_wr),
        .index_val_i (index_val),
        .capture_i   (capture_s),
        .word_i      (mem_rdata),
        .word_mod_o  (word_mod_s)
    );

    // Next-state, capture and registered-output logic.
    always_comb begin
        state_d       = state_q;
        capture_s     = 1'b0;
        ir_d          = ir_q;
        extracode_d   = extracode_q;
        ext_pending_d = ext_pending_q;

        case (state_q)
            EMPTY, HOLD: begin
                if (ir_load) begin
                    state_d = WAIT_MEM;
                end else begin
                    state_d = state_q;
                end
            end
            WAIT_MEM: begin
                if (mem_valid) begin
                    state_d   = HOLD;
                    capture_s = 1'b1;
                end else begin
                    state_d = WAIT_MEM;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (capture_s) begin
            ir_d        = word_mod_s;
            extracode_d = ext_pending_q;
        end else begin
            ir_d        = ir_q;
            extracode_d = extracode_q;
        end

        // A new EXTEND beats the clear-on-capture: it belongs to the next word.
        if (ext_flag) begin
            ext_pending_d = 1'b1;
        end else if (capture_s) begin
            ext_pending_d = 1'b0;
        end else begin
            ext_pending_d = ext_pending_q;
        end

        fetch_req_d = (state_d == WAIT_MEM);
        ir_valid_d  = (state_d == HOLD);
    end

    // State and held-instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            ir_q          <= {WORD_W{1'b0}};
            extracode_q   <= 1'b0;
            ext_pending_q <= 1'b0;
            fetch_req_q   <= 1'b0;
            ir_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            extracode_q   <= extracode_d;
            ext_pending_q <= ext_pending_d;
            fetch_req_q   <= fetch_req_d;
            ir_valid_q    <= ir_valid_d;
        end
    end

    assign fetch_req = fetch_req_q;
    assign ir_valid  = ir_valid_q;
    assign extracode = extracode_q;
    assign ir        = ir_q;
    // Fields are slices of the registered word, so they never glitch.
    assign opcode    = opc_of(ir_q);
    assign qc        = qc_of(ir_q);
    assign addr      = ir_q[ADDR_HI:0];

endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level reference model of the decoder.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ir_load;
    logic [14:0] mem_rdata;
    logic        mem_valid;
    logic        ext_flag;
    logic        index_wr;
    logic [14:0] index_val;
    logic        fetch_req;
    logic [14:0] ir;
    logic [2:0]  opcode;
    logic [1:0]  qc;
    logic [11:0] addr;
    logic        extracode;
    logic        ir_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a fetch is outstanding or not, an instruction is held
    // or not, plus the pending EXTEND/INDEX and the last captured word.
    bit m_outstanding;
    bit m_have;
    int m_ir;
    int m_xc;
    int m_idx;
    int m_pend;

    instr_decode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir_load   (ir_load),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .ext_flag  (ext_flag),
        .index_wr  (index_wr),
        .index_val (index_val),
        .fetch_req (fetch_req),
        .ir        (ir),
        .opcode    (opcode),
        .qc        (qc),
        .addr      (addr),
        .extracode (extracode),
        .ir_valid  (ir_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_outstanding = 1'b0;
        m_have        = 1'b0;
        m_ir          = 0;
        m_xc          = 0;
        m_idx         = 0;
        m_pend        = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".fetch_req"}, {31'd0, fetch_req}, m_outstanding ? 32'd1 : 32'd0);
        check({tag, ".ir_valid"},  {31'd0, ir_valid},  (m_have && !m_outstanding) ? 32'd1 : 32'd0);
        check({tag, ".ir"},        {17'd0, ir},        m_ir);
        check({tag, ".opcode"},    {29'd0, opcode},    m_ir / 4096);
        check({tag, ".qc"},        {30'd0, qc},        (m_ir / 1024) % 4);
        check({tag, ".addr"},      {20'd0, addr},      m_ir % 4096);
        check({tag, ".extracode"}, {31'd0, extracode}, m_xc);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input bit ld, input bit mv, input int rd,
                        input bit ex, input bit iw, input int iv, input string tag);
        bit cap;
        ir_load   = ld;
        mem_valid = mv;
        mem_rdata = rd[14:0];
        ext_flag  = ex;
        index_wr  = iw;
        index_val = iv[14:0];
        @(posedge clk);
        cap = m_outstanding && mv;
        if (cap) begin
            m_ir = (rd + m_idx) % 32768;
            m_xc = m_pend;
        end
        if (iw)       m_idx = iv;
        else if (cap) m_idx = 0;
        if (ex)       m_pend = 1;
        else if (cap) m_pend = 0;
        if (cap) begin
            m_outstanding = 1'b0;
            m_have        = 1'b1;
        end else if (!m_outstanding && ld) begin
            m_outstanding = 1'b1;
            m_have        = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    // Request, wait `stall` cycles, then return `word`.
    task automatic fetch(input int word, input int stall, input string tag);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, {tag, ".req"});
        for (int i = 0; i < stall; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, {tag, ".wait"});
        step(1'b0, 1'b1, word, 1'b0, 1'b0, 0, {tag, ".cap"});
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".fetch_req"}, {31'd0, fetch_req}, 32'd0);
        check({tag, ".ir_valid"},  {31'd0, ir_valid},  32'd0);
        check({tag, ".ir"},        {17'd0, ir},        32'd0);
        check({tag, ".opcode"},    {29'd0, opcode},    32'd0);
        check({tag, ".qc"},        {30'd0, qc},        32'd0);
        check({tag, ".addr"},      {20'd0, addr},      32'd0);
        check({tag, ".extracode"}, {31'd0, extracode}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        ir_load   = 1'b0;
        mem_rdata = 15'd0;
        mem_valid = 1'b0;
        ext_flag  = 1'b0;
        index_wr  = 1'b0;
        index_val = 15'd0;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain fetch, minimum latency.
        fetch(15'o70000, 0, "basic");
        check("basic.opcode7", {29'd0, opcode}, 32'd7);
        check("basic.qc0", {30'd0, qc}, 32'd0);
        check("basic.valid", {31'd0, ir_valid}, 32'd1);

        // EXTEND applies to exactly one following instruction.
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0, "ext.pulse");
        fetch(15'o52000, 0, "ext1");
        check("ext1.opcode5", {29'd0, opcode}, 32'd5);
        check("ext1.qc1", {30'd0, qc}, 32'd1);
        check("ext1.xc1", {31'd0, extracode}, 32'd1);
        fetch(15'o52000, 1, "ext2");
        check("ext2.xc0", {31'd0, extracode}, 32'd0);

        // INDEX modification, one-shot, and wrap-around.
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, 15'o00005, "idx.wr");
        fetch(15'o30100, 0, "idx1");
        check("idx1.ir", {17'd0, ir}, 32'o30105);
        check("idx1.addr", {20'd0, addr}, 32'o0105);
        fetch(15'o30100, 0, "idx2");
        check("idx2.ir", {17'd0, ir}, 32'o30100);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, 15'o00003, "idx.wr_a");
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, 15'o77777, "idx.wr_b");
        fetch(15'o00001, 0, "wrap");
        check("wrap.ir", {17'd0, ir}, 32'd0);

        // EXTEND and INDEX on the capture edge belong to the next word.
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, "coin.req");
        step(1'b0, 1'b1, 15'o12345, 1'b1, 1'b1, 1, "coin.cap");
        check("coin.xc0", {31'd0, extracode}, 32'd0);
        check("coin.ir", {17'd0, ir}, 32'o12345);
        fetch(15'o12345, 0, "coin2");
        check("coin2.xc1", {31'd0, extracode}, 32'd1);
        check("coin2.ir", {17'd0, ir}, 32'o12346);

        // Stall with extra ir_load pulses: one fetch, old outputs held.
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, "stall.req");
        for (int i = 0; i < 5; i++) begin
            step(i[0] ? 1'b0 : 1'b1, 1'b0, 15'o77777, 1'b0, 1'b0, 0, "stall.wait");
            check("stall.held", {17'd0, ir}, 32'o12346);
        end
        step(1'b1, 1'b1, 15'o44444, 1'b0, 1'b0, 0, "stall.cap");
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, "stall.after");

        // Reset in the middle of a fetch with EXTEND pending.
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0, "rst.ext");
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, "rst.req");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst.async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 15'o66666, 1'b0, 1'b0, 0, "rst.stray_mv");
        fetch(15'o52000, 0, "rst.fetch");
        check("rst.xc0", {31'd0, extracode}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 4),
                 int'($urandom_range(0, 32767)),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 32767)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
